// File: rtl/ci_burst_master.sv
// Burst initiator for the custom-instruction (CI) memory protocol.
// One command (direction, start address, word count) becomes one CI
// transaction per word. Write bursts pull words from a valid/ready input
// stream; read bursts push results onto a valid/ready output stream.
// A per-transaction cycle counter aborts a burst whose responder stalls.
module ci_burst_master #(
    parameter logic [7:0] customId      = 8'd14,
    parameter int         addrWidth     = 9,
    parameter int         timeoutCycles = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cmdValid,
    output logic                 cmdReady,
    input  logic                 cmdWrite,
    input  logic [addrWidth-1:0] cmdAddr,
    input  logic [addrWidth:0]   cmdCount,
    input  logic [31:0]          wrData,
    input  logic                 wrValid,
    output logic                 wrReady,
    output logic [31:0]          rdData,
    output logic                 rdValid,
    input  logic                 rdReady,
    output logic                 ciStart,
    output logic [7:0]           ciN,
    output logic [31:0]          ciValueA,
    output logic [31:0]          ciValueB,
    input  logic                 ciDone,
    input  logic [31:0]          ciResult,
    output logic                 busy,
    output logic                 error
);

    localparam int TW = $clog2(timeoutCycles + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GETDATA = 3'd1,
        ISSUE   = 3'd2,
        WAIT    = 3'd3,
        OUT     = 3'd4
    } state_t;

    state_t                 state_reg,   state_next;
    logic [addrWidth-1:0]   addr_reg,    addr_next;
    logic [addrWidth:0]     count_reg,   count_next;
    logic                   write_reg,   write_next;
    logic [31:0]            opb_reg,     opb_next;
    logic [31:0]            rd_data_reg, rd_data_next;
    logic [TW-1:0]          timer_reg,   timer_next;
    logic                   error_reg,   error_next;
    logic [TW-1:0]          timer_inc;
    logic                   advance;

    // State and datapath registers; reset abandons any burst in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            count_reg   <= '0;
            write_reg   <= 1'b0;
            opb_reg     <= '0;
            rd_data_reg <= '0;
            timer_reg   <= '0;
            error_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            count_reg   <= count_next;
            write_reg   <= write_next;
            opb_reg     <= opb_next;
            rd_data_reg <= rd_data_next;
            timer_reg   <= timer_next;
            error_reg   <= error_next;
        end
    end

    // Next-state logic: command intake, CI handshake, timeout and word advance.
    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        count_next   = count_reg;
        write_next   = write_reg;
        opb_next     = opb_reg;
        rd_data_next = rd_data_reg;
        timer_next   = timer_reg;
        error_next   = error_reg;
        advance      = 1'b0;
        // First waiting cycle after the start pulse counts as 1.
        timer_inc    = (state_reg == ISSUE) ? TW'(1) : timer_reg + TW'(1);

        case (state_reg)
            IDLE: begin
                if (cmdValid) begin
                    addr_next  = cmdAddr;
                    count_next = cmdCount;
                    write_next = cmdWrite;
                    error_next = 1'b0;
                    timer_next = '0;
                    if (cmdCount != '0) begin
                        state_next = cmdWrite ? GETDATA : ISSUE;
                    end
                end
            end
            GETDATA: begin
                if (wrValid) begin
                    opb_next   = wrData;
                    state_next = ISSUE;
                end
            end
            ISSUE, WAIT: begin
                if (ciDone) begin
                    timer_next = '0;
                    if (write_reg) begin
                        advance = 1'b1;
                    end else begin
                        rd_data_next = ciResult;
                        state_next   = OUT;
                    end
                end else if (timer_inc == TW'(timeoutCycles)) begin
                    // Responder stalled: flag it and drop the rest of the burst.
                    timer_next = '0;
                    error_next = 1'b1;
                    state_next = IDLE;
                end else begin
                    timer_next = timer_inc;
                    state_next = WAIT;
                end
            end
            OUT: begin
                if (rdReady) begin
                    advance = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (advance) begin
            addr_next  = addr_reg + 1'b1;
            count_next = count_reg - 1'b1;
            if (count_reg == (addrWidth + 1)'(1)) begin
                state_next = IDLE;
            end else begin
                state_next = write_reg ? GETDATA : ISSUE;
            end
        end
    end

    // Outputs decode from state; operands come straight from the held registers.
    assign cmdReady = (state_reg == IDLE) && !reset;
    assign busy     = (state_reg != IDLE);
    assign wrReady  = (state_reg == GETDATA);
    assign rdValid  = (state_reg == OUT);
    assign rdData   = rd_data_reg;
    assign ciStart  = (state_reg == ISSUE);
    assign ciN      = customId;
    assign ciValueA = {{(31 - addrWidth){1'b0}}, write_reg, addr_reg};
    assign ciValueB = write_reg ? opb_reg : 32'h0;
    assign error    = error_reg;

endmodule

// File: tb/tb_ci_burst_master.sv
// Self-checking bench for ci_burst_master: directed protocol scenarios plus
// randomized bursts against a word-level memory model and a CI responder.
module tb_ci_burst_master;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmdValid, cmdReady, cmdWrite;
    logic [8:0]  cmdAddr;
    logic [9:0]  cmdCount;
    logic [31:0] wrData;
    logic        wrValid, wrReady;
    logic [31:0] rdData;
    logic        rdValid, rdReady;
    logic        ciStart;
    logic [7:0]  ciN;
    logic [31:0] ciValueA, ciValueB;
    logic        ciDone;
    logic [31:0] ciResult;
    logic        busy, error;

    int tests_run    = 0;
    int tests_failed = 0;

    ci_burst_master dut (
        .clock(clock), .reset(reset),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdWrite(cmdWrite),
        .cmdAddr(cmdAddr), .cmdCount(cmdCount),
        .wrData(wrData), .wrValid(wrValid), .wrReady(wrReady),
        .rdData(rdData), .rdValid(rdValid), .rdReady(rdReady),
        .ciStart(ciStart), .ciN(ciN), .ciValueA(ciValueA), .ciValueB(ciValueB),
        .ciDone(ciDone), .ciResult(ciResult),
        .busy(busy), .error(error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- CI memory responder ----------------
    logic [31:0] resp_mem [512];
    logic [31:0] model_mem [512];
    int  resp_lat   = 0;
    bit  resp_never = 1'b0;
    bit  resp_force = 1'b0;
    int  pend       = 0;
    bit  resp_active = 1'b0;

    assign ciDone   = resp_force || (!resp_never && ((resp_lat == 0 && ciStart) || pend == 1));
    assign ciResult = resp_mem[ciValueA[8:0]];

    always @(posedge clock) begin
        if (reset || resp_never || ciDone) pend <= 0;
        else if (ciStart && resp_lat != 0) pend <= resp_lat;
        else if (pend > 1) pend <= pend - 1;
        if (ciDone && (ciStart || resp_active) && ciValueA[9])
            resp_mem[ciValueA[8:0]] <= ciValueB;
        if (reset || resp_never || ciDone) resp_active <= 1'b0;
        else if (ciStart) resp_active <= 1'b1;
    end

    // ---------------- monitor ----------------
    int          cyc = 0;
    logic [31:0] start_a[$], start_b[$], rd_q[$];
    int          start_cyc[$], rd_cyc[$], rv_rise[$], wr_cyc[$];
    int          busy_fall = 0, err_rise = 0;
    bit          in_txn = 1'b0, prev_stall = 1'b0, prev_rv = 1'b0, prev_busy = 1'b0, prev_err = 1'b0;
    logic [31:0] prev_a = 0, prev_b = 0, prev_rd = 0;

    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            if (reset || !busy) in_txn = 1'b0;
            else if (in_txn) begin
                check("ciA_stable", ciValueA, prev_a);
                check("ciB_stable", ciValueB, prev_b);
            end
            if (ciStart && !ciDone) in_txn = 1'b1;
            if (ciDone) in_txn = 1'b0;
            if (prev_stall && !reset) begin
                check("rd_hold_valid", rdValid, 1);
                check("rd_hold_data", rdData, prev_rd);
            end
            if (ciStart) begin
                start_a.push_back(ciValueA);
                start_b.push_back(ciValueB);
                start_cyc.push_back(cyc);
            end
            if (rdValid && !prev_rv) rv_rise.push_back(cyc);
            if (rdValid && rdReady) begin
                rd_q.push_back(rdData);
                rd_cyc.push_back(cyc);
            end
            if (wrValid && wrReady) wr_cyc.push_back(cyc);
            if (!busy && prev_busy) busy_fall = cyc;
            if (error && !prev_err) err_rise = cyc;
            prev_stall = rdValid && !rdReady;
            prev_rv    = rdValid;
            prev_busy  = busy;
            prev_err   = error;
            prev_a     = ciValueA;
            prev_b     = ciValueB;
            prev_rd    = rdData;
        end
    end

    task automatic clear_mon();
        start_a.delete(); start_b.delete(); start_cyc.delete();
        rd_q.delete(); rd_cyc.delete(); rv_rise.delete(); wr_cyc.delete();
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] burst_data[$];

    task automatic send_cmd(input bit wr, input int addr, input int cnt);
        cmdValid = 1'b1;
        cmdWrite = wr;
        cmdAddr  = 9'(addr);
        cmdCount = 10'(cnt);
        @(negedge clock);
        check("cmd_ready", cmdReady, 1);
        @(posedge clock); #1;
        cmdValid = 1'b0;
    endtask

    // One full burst; expectations come from address arithmetic and model_mem.
    task automatic run_burst(input bit wr, input int addr, input int cnt, input int lat,
                             input bit never, input int gap_pct, input int stall_pct,
                             input int stall_first);
        logic [31:0] exp_a[$], exp_b[$], exp_rd[$];
        int idx = 0;
        int stall_left = stall_first;
        bit finished = 1'b0;
        int exp_n;
        resp_lat   = lat;
        resp_never = never;
        clear_mon();
        for (int i = 0; i < cnt; i++) begin
            int a = (addr + i) % 512;
            exp_a.push_back({22'h0, wr, 9'(a)});
            exp_b.push_back(wr ? burst_data[i] : 32'h0);
            exp_rd.push_back(model_mem[a]);
        end
        if (wr && !never)
            for (int i = 0; i < cnt; i++) model_mem[(addr + i) % 512] = burst_data[i];
        send_cmd(wr, addr, cnt);
        for (int k = 0; k < 3000 && !finished; k++) begin
            wrValid = (idx < burst_data.size()) && ($urandom_range(99) >= gap_pct);
            wrData  = (idx < burst_data.size()) ? burst_data[idx] : 32'h0;
            rdReady = (stall_left > 0) ? 1'b0 : ($urandom_range(99) >= stall_pct);
            @(negedge clock);
            if (wrValid && wrReady) idx++;
            if (rdValid && stall_left > 0) stall_left--;
            if (!busy) finished = 1'b1;
            @(posedge clock); #1;
        end
        wrValid = 1'b0;
        rdReady = 1'b0;
        check("burst_finished", finished, 1);
        exp_n = never ? 1 : cnt;
        check("n_starts", start_a.size(), exp_n);
        for (int i = 0; i < exp_n && i < start_a.size(); i++) begin
            check("ciValueA", start_a[i], exp_a[i]);
            check("ciValueB", start_b[i], exp_b[i]);
        end
        if (!wr) begin
            check("n_reads", rd_q.size(), never ? 0 : cnt);
            for (int i = 0; i < rd_q.size() && i < cnt && !never; i++)
                check("rdData", rd_q[i], exp_rd[i]);
        end
        check("error", error, never ? 1 : 0);
        check("cmdReady_after", cmdReady, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) begin
            resp_mem[i]  = 32'h0;
            model_mem[i] = 32'h0;
        end
        reset = 1'b1; cmdValid = 0; cmdWrite = 0; cmdAddr = 0; cmdCount = 0;
        wrData = 0; wrValid = 0; rdReady = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_ciStart", ciStart, 0);
        check("rst_busy", busy, 0);
        check("rst_cmdReady", cmdReady, 0);
        check("rst_rdValid", rdValid, 0);
        check("rst_error", error, 0);
        check("rst_ciValueA", ciValueA, 0);
        check("rst_ciN", ciN, 8'd14);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_release_cmdReady", cmdReady, 1);
        @(posedge clock); #1;

        // Write with address wrap, combinational done.
        burst_data = '{32'h11, 32'h22, 32'h33};
        run_burst(1'b1, 'h1FE, 3, 0, 1'b0, 0, 0, 0);
        if (wr_cyc.size() > 0) check("wr_cycles", busy_fall - wr_cyc[0], 6);
        else check("wr_handshake_seen", 0, 1);

        // Read back with wrap, done one cycle after start.
        burst_data.delete();
        run_burst(1'b0, 'h1FE, 3, 1, 1'b0, 0, 0, 0);
        for (int i = 0; i < 3 && i < rd_q.size(); i++)
            check("rd_const", rd_q[i], 32'h11 * (i + 1));
        for (int i = 0; i < rv_rise.size() && i < start_cyc.size(); i++)
            check("rdValid_latency", rv_rise[i] - start_cyc[i], 2);

        // Read backpressure: second start only after first rd handshake.
        run_burst(1'b0, 'h1FE, 2, 1, 1'b0, 0, 0, 5);
        if (start_cyc.size() > 1 && rd_cyc.size() > 0)
            check("bp_second_start", start_cyc[1], rd_cyc[0] + 1);
        else check("bp_events_seen", 0, 1);

        // Timeout: responder never completes.
        run_burst(1'b0, 'h010, 4, 0, 1'b1, 0, 0, 0);
        if (start_cyc.size() > 0) check("timeout_cycles", err_rise - start_cyc[0], 16);
        check("timeout_no_rdValid", rv_rise.size(), 0);
        check("timeout_busy", busy, 0);
        resp_never = 1'b0;

        // Zero-count command clears error; stray done while idle is ignored.
        clear_mon();
        send_cmd(1'b0, 'h020, 0);
        @(negedge clock);
        check("zero_clears_error", error, 0);
        check("zero_busy", busy, 0);
        @(posedge clock); #1;
        resp_force = 1'b1;
        @(negedge clock);
        check("stray_busy", busy, 0);
        @(posedge clock); #1;
        resp_force = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("stray_no_start", start_a.size(), 0);
        check("stray_cmdReady", cmdReady, 1);
        check("stray_error", error, 0);

        // Randomized bursts against the memory model.
        for (int r = 0; r < 12; r++) begin
            bit wr = 1'($urandom_range(0, 1));
            int cnt = $urandom_range(1, 6);
            int addr = (r % 3 == 0) ? $urandom_range(508, 511) : $urandom_range(0, 511);
            burst_data.delete();
            if (wr) for (int i = 0; i < cnt; i++) burst_data.push_back($urandom);
            run_burst(wr, addr, cnt, $urandom_range(0, 3), 1'b0, 30, 30, 0);
            $display("[TB] burst %0d: %s addr=0x%0h count=%0d", r, wr ? "write" : "read", addr, cnt);
        end

        // Mid-burst reset while waiting on the responder.
        resp_never = 1'b1;
        send_cmd(1'b0, 'h005, 3);
        repeat (3) @(posedge clock);
        #1;
        check("pre_reset_busy", busy, 1);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ciStart", ciStart, 0);
        check("mid_rst_ciValueA", ciValueA, 0);
        check("mid_rst_ciValueB", ciValueB, 0);
        check("mid_rst_rdValid", rdValid, 0);
        check("mid_rst_rdData", rdData, 0);
        check("mid_rst_wrReady", wrReady, 0);
        check("mid_rst_cmdReady", cmdReady, 0);
        check("mid_rst_error", error, 0);
        check("mid_rst_ciN", ciN, 8'd14);
        @(posedge clock); #1;
        reset = 1'b0;
        resp_never = 1'b0;
        @(negedge clock);
        check("post_rst_cmdReady", cmdReady, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
